// File: rtl/bram_access_sched.sv
// rtl/bram_access_sched.sv - shares one BRAM between single-beat loader writes and strided read bursts
//
// Purpose: grants loader writes whenever idle (writes win over read commands),
// otherwise accepts a burst command and issues one byte address per cycle
// (addr, addr+stride, ...) onto the BRAM read port. Read data comes back one
// cycle later straight from the BRAM, tagged with valid/last.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_req/wr_addr_in/wr_data_in, wr_gnt       loader write beat handshake
//   rd_cmd_valid/ready, rd_cmd_base/len/stride burst command (len 0 = 256 beats)
//   rd_data_valid/rd_data/rd_data_last         returned read beats, no back-pressure
//   busy                                       burst in flight or beat pending
//   bram_we/bram_wr_addr/bram_data_in          BRAM write port
//   bram_rd_addr/bram_data_out                 BRAM read port (byte address)
module bram_access_sched #(
  parameter int WR_AW = 7,
  parameter int RD_AW = 20,
  parameter int WR_DW = 64,
  parameter int RD_DW = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WR_AW-1:0] wr_addr_in,
  input  logic [WR_DW-1:0] wr_data_in,
  output logic             wr_gnt,
  input  logic             rd_cmd_valid,
  output logic             rd_cmd_ready,
  input  logic [RD_AW-1:0] rd_cmd_base,
  input  logic [LEN_W-1:0] rd_cmd_len,
  input  logic [LEN_W-1:0] rd_cmd_stride,
  output logic             rd_data_valid,
  output logic [RD_DW-1:0] rd_data,
  output logic             rd_data_last,
  output logic             busy,
  output logic             bram_we,
  output logic [WR_AW-1:0] bram_wr_addr,
  output logic [WR_DW-1:0] bram_data_in,
  output logic [RD_AW-1:0] bram_rd_addr,
  input  logic [RD_DW-1:0] bram_data_out
);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t           state;
  logic [RD_AW-1:0] addr;
  logic [LEN_W:0]   remaining;   // one extra bit so len 0 can hold 2^LEN_W
  logic [LEN_W-1:0] stride;

  // Writes only in IDLE; a pending write also blocks command acceptance.
  assign wr_gnt       = wr_req && (state == IDLE);
  assign rd_cmd_ready = (state == IDLE) && !wr_req;

  assign bram_we      = wr_gnt;
  assign bram_wr_addr = wr_addr_in;
  assign bram_data_in = wr_data_in;

  // The address register drives the read port directly; it is frozen on the
  // final beat so the port keeps showing the last issued address while idle.
  assign bram_rd_addr = addr;
  assign rd_data      = bram_data_out;

  assign busy = (state == READ) || rd_data_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      stride        <= '0;
      rd_data_valid <= 1'b0;
      rd_data_last  <= 1'b0;
    end else begin
      // Return tags trail the issue cycle by one, matching the BRAM latency.
      rd_data_valid <= (state == READ);
      rd_data_last  <= (state == READ) && (remaining == (LEN_W+1)'(1));

      case (state)
        IDLE: begin
          if (rd_cmd_valid && rd_cmd_ready) begin
            addr      <= rd_cmd_base;
            remaining <= (rd_cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                            : {1'b0, rd_cmd_len};
            stride    <= rd_cmd_stride;
            state     <= READ;
          end
        end
        READ: begin
          remaining <= remaining - (LEN_W+1)'(1);
          if (remaining == (LEN_W+1)'(1)) begin
            state <= IDLE;
          end else begin
            // Unsigned stride, wraps modulo 2^RD_AW.
            addr <= addr + {{(RD_AW-LEN_W){1'b0}}, stride};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_access_sched.sv
// tb/tb_bram_access_sched.sv - randomized self-checking bench for bram_access_sched
module tb_bram_access_sched;

  logic        clk;
  logic        rst_n;
  logic        wr_req;
  logic [6:0]  wr_addr_in;
  logic [63:0] wr_data_in;
  logic        wr_gnt;
  logic        rd_cmd_valid;
  logic        rd_cmd_ready;
  logic [19:0] rd_cmd_base;
  logic [7:0]  rd_cmd_len;
  logic [7:0]  rd_cmd_stride;
  logic        rd_data_valid;
  logic [31:0] rd_data;
  logic        rd_data_last;
  logic        busy;
  logic        bram_we;
  logic [6:0]  bram_wr_addr;
  logic [63:0] bram_data_in;
  logic [19:0] bram_rd_addr;
  logic [31:0] bram_data_out;

  int checks;
  int failures;

  bram_access_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .wr_addr_in   (wr_addr_in),
    .wr_data_in   (wr_data_in),
    .wr_gnt       (wr_gnt),
    .rd_cmd_valid (rd_cmd_valid),
    .rd_cmd_ready (rd_cmd_ready),
    .rd_cmd_base  (rd_cmd_base),
    .rd_cmd_len   (rd_cmd_len),
    .rd_cmd_stride(rd_cmd_stride),
    .rd_data_valid(rd_data_valid),
    .rd_data      (rd_data),
    .rd_data_last (rd_data_last),
    .busy         (busy),
    .bram_we      (bram_we),
    .bram_wr_addr (bram_wr_addr),
    .bram_data_in (bram_data_in),
    .bram_rd_addr (bram_rd_addr),
    .bram_data_out(bram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the BRAM as seen through the 32-bit read port: a fixed
  // scramble of the word index, so a wrong address yields wrong data.
  function automatic logic [31:0] word_at(input logic [19:0] byte_addr);
    logic [31:0] idx;
    idx = {14'h0, byte_addr[19:2]};
    return (idx * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // BRAM read port: one-cycle latency, output held in any write cycle.
  always @(posedge clk) begin
    if (!bram_we) bram_data_out <= word_at(bram_rd_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One loader beat; optionally collides with a read command that must lose.
  task automatic do_write(input logic [6:0] a, input logic [63:0] d, input bit collide);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr_in = a; wr_data_in = d;
    if (collide) begin
      rd_cmd_valid = 1'b1; rd_cmd_len = 8'd3; rd_cmd_stride = 8'd4; rd_cmd_base = 20'h00100;
    end
    @(negedge clk);
    check("wr_gnt", wr_gnt, 1);
    check("wr_we", bram_we, 1);
    check("wr_addr", bram_wr_addr, a);
    check("wr_data", bram_data_in, d);
    check("wr_blocks_ready", rd_cmd_ready, 0);
    @(posedge clk); #1;
    wr_req = 1'b0; rd_cmd_valid = 1'b0;
    @(negedge clk);
    check("wr_one_cycle_we", bram_we, 0);
    check("wr_idle_busy", busy, 0);
    check("wr_idle_ready", rd_cmd_ready, 1);
  endtask

  // One burst. wr_at: issue index at which the loader raises wr_req (>= beats: none).
  task automatic do_burst(input logic [19:0] base, input logic [7:0] len,
                          input logic [7:0] stride, input int wr_at);
    int n;
    logic [19:0] exp_a;
    logic [19:0] prev_a;
    logic [6:0]  wa;
    logic [63:0] wd;
    n = (len == 8'd0) ? 256 : int'(len);
    prev_a = '0;
    wa = 7'($urandom);
    wd = {$urandom, $urandom};
    @(posedge clk); #1;
    rd_cmd_valid = 1'b1; rd_cmd_base = base; rd_cmd_len = len; rd_cmd_stride = stride;
    @(negedge clk);
    check("cmd_ready", rd_cmd_ready, 1);
    check("pre_busy", busy, 0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_cmd_valid = 1'b0;
      rd_cmd_base = 20'($urandom); rd_cmd_len = 8'($urandom); rd_cmd_stride = 8'($urandom);
      if (i == wr_at) begin
        wr_req = 1'b1; wr_addr_in = wa; wr_data_in = wd;
      end
      exp_a = 20'(32'(base) + i * int'(stride));
      @(negedge clk);
      check("rd_addr", bram_rd_addr, exp_a);
      check("rd_no_we", bram_we, 0);
      check("rd_no_gnt", wr_gnt, 0);
      check("rd_not_ready", rd_cmd_ready, 0);
      check("rd_busy", busy, 1);
      check("rd_valid", rd_data_valid, (i > 0));
      check("rd_last_early", rd_data_last, 0);
      if (i > 0) check("rd_data", rd_data, word_at(prev_a));
      prev_a = exp_a;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("tail_valid", rd_data_valid, 1);
    check("tail_last", rd_data_last, 1);
    check("tail_data", rd_data, word_at(prev_a));
    check("tail_busy", busy, 1);
    check("tail_addr_hold", bram_rd_addr, prev_a);
    check("tail_gnt", wr_gnt, (wr_at < n));
    check("tail_ready", rd_cmd_ready, (wr_at >= n));
    if (wr_at < n) begin
      check("tail_wr_addr", bram_wr_addr, wa);
      check("tail_wr_data", bram_data_in, wd);
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    check("post_valid", rd_data_valid, 0);
    check("post_busy", busy, 0);
    check("post_ready", rd_cmd_ready, 1);
    check("post_addr_hold", bram_rd_addr, prev_a);
  endtask

  // Burst interrupted by reset after k issue cycles.
  task automatic do_reset_mid_burst(input int k);
    @(posedge clk); #1;
    rd_cmd_valid = 1'b1; rd_cmd_base = 20'h00400; rd_cmd_len = 8'd20; rd_cmd_stride = 8'd4;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      rd_cmd_valid = 1'b0;
    end
    @(negedge clk);
    check("mid_busy", busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_valid", rd_data_valid, 0);
    check("rst_last", rd_data_last, 0);
    check("rst_busy", busy, 0);
    check("rst_we", bram_we, 0);
    check("rst_rd_addr", bram_rd_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", rd_cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rel_no_stale", rd_data_valid, 0);
      check("rel_idle", busy, 0);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; wr_req = 1'b0; wr_addr_in = '0; wr_data_in = '0;
    rd_cmd_valid = 1'b0; rd_cmd_base = '0; rd_cmd_len = '0; rd_cmd_stride = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", rd_data_valid, 0);
    check("reset_last", rd_data_last, 0);
    check("reset_busy", busy, 0);
    check("reset_rd_addr", bram_rd_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", rd_cmd_ready, 1);

    do_write(7'd5, 64'hA5A5_0000_1234_5678, 1'b0);
    do_burst(20'h00010, 8'd4, 8'd4, 99);
    do_burst(20'h00000, 8'd0, 8'd1, 999);
    do_burst(20'hFFFF8, 8'd3, 8'd8, 99);
    do_burst(20'h00200, 8'd6, 8'd4, 2);
    do_burst(20'h00033, 8'd1, 8'd0, 0);
    do_write(7'd127, 64'hFFFF_0000_FFFF_0000, 1'b1);
    do_burst(20'h01001, 8'd5, 8'd3, 99);
    do_reset_mid_burst(3);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_write(7'($urandom), {$urandom, $urandom}, 1'($urandom));
      end else begin
        logic [7:0] l;
        l = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
        do_burst(20'($urandom), l, 8'($urandom), int'($urandom_range(0, 16)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
